modred_arbiter: RTL and testbench

//  Shares one modred_32 reduction pipeline (C = D mod q, latency 4) between NUM_REQ

---
 rtl/ntt_pkg.sv | 10 +
 rtl/modred_32.sv | 49 ++++
 rtl/rr_arbiter.sv | 26 ++
 rtl/modred_arbiter.sv | 100 ++++++++++
 tb/tb_modred_arbiter.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/ntt_pkg.sv
// ntt_pkg: shared constants and helpers for the NTT reduction datapath
package ntt_pkg;
  localparam int RED_LAT = 4;
  localparam logic [12:0] MODRED_Q_LOW = 13'h0001;
  function automatic int clog2(input int n);
    int r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/modred_32.sv
// modred_32: four-stage pipelined c = d mod q, exact for d < q*2^32
module modred_32 (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] d,
  input  logic [31:0] q,
  output logic [31:0] c
);
  logic [31:0] r0, r1, r2, r3, q0, q1, q2;
  logic [23:0] lo0;
  logic [15:0] lo1;
  logic [7:0]  lo2;
  function automatic logic [31:0] step8(input logic [31:0] r, input logic [7:0] b, input logic [31:0] m);
    logic [32:0] t;
    logic [31:0] x;
    x = r;
    for (int i = 7; i >= 0; i--) begin
      t = {x, b[i]};
      x = (t >= {1'b0, m}) ? 32'(t - {1'b0, m}) : t[31:0];
    end
    return x;
  endfunction
  always_ff @(posedge clk) begin
    if (rst) begin
      r0 <= '0;
      r1 <= '0;
      r2 <= '0;
      r3 <= '0;
      q0 <= '0;
      q1 <= '0;
      q2 <= '0;
      lo0 <= '0;
      lo1 <= '0;
      lo2 <= '0;
    end else begin
      r0 <= step8(d[63:32], d[31:24], q);
      lo0 <= d[23:0];
      q0 <= q;
      r1 <= step8(r0, lo0[23:16], q0);
      lo1 <= lo0[15:0];
      q1 <= q0;
      r2 <= step8(r1, lo1[15:8], q1);
      lo2 <= lo1[7:0];
      q2 <= q1;
      r3 <= step8(r2, lo2, q2);
    end
  end
  assign c = r3;
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: picks the first active request at or after ptr, wrapping
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] gid,
  output logic         any
);
  logic [W-1:0] idx;
  always_comb begin
    gid = '0;
    any = 1'b0;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = W'((int'(ptr) + k) % N);
      if (req[idx]) begin
        gid = idx;
        any = 1'b1;
      end
    end
    gnt = any ? N'(1) << gid : '0;
  end
endmodule

// File: rtl/modred_arbiter.sv
// modred_arbiter: round-robin sharing of one modred_32 pipeline with tagged result routing
module modred_arbiter import ntt_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int IDW = clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*64-1:0] req_d,
  input  logic [NUM_REQ*32-1:0] req_q,
  output logic [NUM_REQ-1:0]    resp_valid,
  output logic [31:0]           resp_c,
  output logic [IDW-1:0]        resp_id,
  output logic                  idle,
  output logic                  cfg_err
);
  logic [63:0] d_arr [NUM_REQ];
  logic [31:0] q_arr [NUM_REQ];
  logic [NUM_REQ-1:0] gnt;
  logic [IDW-1:0] gid, ptr, iss_id;
  logic any, hs, iss_v, busy;
  logic [63:0] iss_d;
  logic [31:0] iss_q, c;
  logic tag_v [RED_LAT];
  logic [IDW-1:0] tag_id [RED_LAT];
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign d_arr[i] = req_d[64*i +: 64];
    assign q_arr[i] = req_q[32*i +: 32];
  end
  rr_arbiter #(.N(NUM_REQ), .W(IDW)) u_rr (
    .req(req_valid),
    .ptr(ptr),
    .gnt(gnt),
    .gid(gid),
    .any(any)
  );
  modred_32 u_red (
    .clk(clk),
    .rst(rst),
    .d(iss_d),
    .q(iss_q),
    .c(c)
  );
  assign hs = any & en;
  assign req_ready = en ? gnt : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
      iss_v <= 1'b0;
      iss_d <= '0;
      iss_q <= '0;
      iss_id <= '0;
      cfg_err <= 1'b0;
    end else begin
      iss_v <= hs;
      if (hs) begin
        iss_d <= d_arr[gid];
        iss_q <= q_arr[gid];
        iss_id <= gid;
        ptr <= (gid == IDW'(NUM_REQ - 1)) ? '0 : gid + 1'b1;
        cfg_err <= cfg_err | (q_arr[gid][12:0] != MODRED_Q_LOW);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < RED_LAT; k++) begin
        tag_v[k] <= 1'b0;
        tag_id[k] <= '0;
      end
    end else begin
      tag_v[0] <= iss_v;
      tag_id[0] <= iss_id;
      for (int k = 1; k < RED_LAT; k++) begin
        tag_v[k] <= tag_v[k-1];
        tag_id[k] <= tag_id[k-1];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid <= '0;
      resp_c <= '0;
      resp_id <= '0;
    end else begin
      resp_valid <= tag_v[RED_LAT-1] ? NUM_REQ'(1) << tag_id[RED_LAT-1] : '0;
      if (tag_v[RED_LAT-1]) begin
        resp_c <= c;
        resp_id <= tag_id[RED_LAT-1];
      end
    end
  end
  always_comb begin
    busy = iss_v;
    for (int k = 0; k < RED_LAT; k++) busy = busy | tag_v[k];
  end
  assign idle = ~busy;
endmodule

// File: tb/tb_modred_arbiter.sv
// tb_modred_arbiter: randomized and directed checks against a transaction-level model
module tb_modred_arbiter;
  import ntt_pkg::*;
  localparam int N = 4;
  localparam int W = 2;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b0;
  logic [N-1:0] req_valid = '0;
  logic [N-1:0] req_ready, resp_valid;
  logic [N*64-1:0] req_d = '0;
  logic [N*32-1:0] req_q = '0;
  logic [31:0] resp_c;
  logic [W-1:0] resp_id;
  logic idle, cfg_err;
  always #5 clk = ~clk;
  modred_arbiter #(.NUM_REQ(N), .IDW(W)) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_d(req_d),
    .req_q(req_q),
    .resp_valid(resp_valid),
    .resp_c(resp_c),
    .resp_id(resp_id),
    .idle(idle),
    .cfg_err(cfg_err)
  );
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  logic [63:0] rd [N];
  logic [31:0] rq [N];
  bit pend [N];
  int mptr = 0;
  int last_hs = -100;
  bit mcfg = 0;
  bit xv [8192];
  bit xk [8192];
  int xid [8192];
  logic [31:0] xc [8192];
  logic [31:0] mc = '0;
  int mid = 0;
  bit mc_ok = 1;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask
  function automatic int winner();
    for (int k = 0; k < N; k++) if (pend[(mptr + k) % N]) return (mptr + k) % N;
    return -1;
  endfunction
  task automatic new_req(input int i, input logic [63:0] d, input logic [31:0] q);
    rd[i] = d;
    rq[i] = q;
    pend[i] = 1;
  endtask
  task automatic gen(input logic [N-1:0] want);
    logic [31:0] q, hi;
    for (int i = 0; i < N; i++) begin
      if (!pend[i] && want[i]) begin
        q = $urandom();
        q[12:0] = 13'h0001;
        hi = 32'($urandom()) % q;
        new_req(i, {hi, 32'($urandom())}, q);
      end else if (pend[i] && !want[i]) begin
        pend[i] = 0;
      end
    end
  endtask
  task automatic cycle(input bit r, input bit e);
    int w, t;
    rst = r;
    en = e;
    for (int i = 0; i < N; i++) begin
      req_valid[i] = pend[i];
      req_d[64*i +: 64] = rd[i];
      req_q[32*i +: 32] = rq[i];
    end
    #1;
    w = winner();
    check("req_ready", req_ready, (e && w >= 0) ? (N'(1) << w) : '0);
    @(posedge clk);
    cyc++;
    if (r) begin
      mptr = 0;
      mcfg = 0;
      last_hs = -100;
      mc = '0;
      mid = 0;
      mc_ok = 1;
      for (int k = 0; k <= RED_LAT + 1; k++) xv[cyc + k] = 0;
    end else begin
      if (xv[cyc]) begin
        mc = xc[cyc];
        mid = xid[cyc];
        mc_ok = xk[cyc];
      end
      if (e && w >= 0) begin
        t = cyc + RED_LAT + 1;
        xv[t] = 1;
        xid[t] = w;
        xk[t] = (rq[w][12:0] == 13'h0001);
        xc[t] = 32'(rd[w] % {32'h0, rq[w]});
        mcfg = mcfg | !xk[t];
        last_hs = cyc;
        mptr = (w + 1) % N;
        pend[w] = 0;
      end
    end
    #1;
    check("resp_valid", resp_valid, xv[cyc] ? (N'(1) << xid[cyc]) : '0);
    if (mc_ok) check("resp_c", resp_c, mc);
    check("resp_id", resp_id, mid);
    check("idle", idle, (cyc - last_hs) > RED_LAT);
    check("cfg_err", cfg_err, mcfg);
    @(negedge clk);
  endtask
  initial begin
    logic [N-1:0] wnt;
    for (int i = 0; i < N; i++) begin
      rd[i] = '0;
      rq[i] = 32'h1;
      pend[i] = 0;
    end
    @(negedge clk);
    cycle(1, 0);
    cycle(1, 0);
    new_req(0, 64'h7FFFE006, 32'h7FFFE001);
    repeat (8) cycle(0, 1);
    for (int i = 0; i < N; i++) new_req(i, 64'h7FFFE001 + 64'(i), 32'h7FFFE001);
    repeat (12) cycle(0, 1);
    repeat (8) begin
      gen(4'b0110);
      cycle(0, 1);
    end
    repeat (8) begin
      gen(4'b0000);
      cycle(0, 1);
    end
    repeat (3) begin
      gen(4'b1111);
      cycle(0, 1);
    end
    repeat (8) begin
      gen(4'b1111);
      cycle(0, 0);
    end
    repeat (6) begin
      gen(4'b1111);
      cycle(0, 1);
    end
    repeat (8) begin
      gen(4'b0000);
      cycle(0, 1);
    end
    repeat (2) begin
      gen(4'b0011);
      cycle(0, 1);
    end
    gen(4'b0000);
    cycle(0, 1);
    cycle(1, 1);
    repeat (8) cycle(0, 1);
    repeat (1500) begin
      for (int i = 0; i < N; i++) wnt[i] = ($urandom() % 4) != 0;
      gen(wnt);
      cycle(($urandom() % 200) == 0, ($urandom() % 8) != 0);
    end
    gen(4'b0000);
    cycle(1, 0);
    new_req(2, 64'h55, 32'h7FFFE000);
    cycle(0, 1);
    repeat (4) begin
      gen(4'b1111);
      cycle(0, 1);
    end
    gen(4'b0000);
    repeat (8) cycle(0, 1);
    cycle(1, 0);
    cycle(0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
